// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmit scheduler.
// Line wrapping is enabled by defining MORSE_LINE_WRAP_EN.
package morse_pkg;

  localparam logic [7:0] SPACE_ADDR = 8'hE0;
  localparam logic [7:0] BAD_CHAR   = 8'h3F;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam int unsigned LINE_LEN_DEF = 80;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOOK,
    ST_FETCH,
    ST_WR,
    ST_SP_LOOK,
    ST_SP_FETCH,
    ST_SP_WR,
    ST_CR_WR,
    ST_LF_WR
  } state_t;

  typedef struct packed {
    logic       wg;
    logic [2:0] cnt;
    logic [4:0] sym;
  } evt_t;

endpackage

// File: rtl/morse_tx_scheduler_if.sv
// Decoder / ROM / UART side signals of the Morse transmit scheduler.
// master drives the events, ROM data and FIFO status; slave is the scheduler.
interface morse_tx_scheduler_if;

  logic       lg;
  logic       wg;
  logic [4:0] symbol;
  logic [2:0] symbol_count;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       tx_full;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       sym_clear;
  logic       busy;
  logic       overflow;

  modport master (
    output lg, wg, symbol, symbol_count,
    output rom_data, tx_full,
    input  rom_addr, w_data, wr_uart,
    input  sym_clear, busy, overflow
  );

  modport slave (
    input  lg, wg, symbol, symbol_count,
    input  rom_data, tx_full,
    output rom_addr, w_data, wr_uart,
    output sym_clear, busy, overflow
  );

endinterface

// File: rtl/morse_evt_slot.sv
// Single-entry pending event register used while the scheduler is busy.
// A push into a full slot is dropped unless the slot is popped that cycle.
module morse_evt_slot
  import morse_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  logic i_pop,
  input  evt_t i_data,
  output evt_t o_data,
  output logic o_full,
  output logic o_overflow
);

  logic r_full;
  evt_t r_data;
  logic w_store;

  assign o_overflow = i_push & r_full & ~i_pop;
  assign w_store    = i_push & ~o_overflow;
  assign o_data     = r_data;
  assign o_full     = r_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (w_store) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/morse_tx_scheduler.sv
// Sequences decoded Morse symbols through the ROM into the UART.
// MORSE_LINE_WRAP_EN adds a column counter and CR/LF insertion.
module morse_tx_scheduler
  import morse_pkg::*;
`ifdef MORSE_LINE_WRAP_EN
  #(parameter int unsigned LINE_LEN = LINE_LEN_DEF)
`endif
(
  input logic clk,
  input logic reset,
  morse_tx_scheduler_if.slave bus
);

  state_t r_state, w_state_nxt;
  evt_t   r_cur, w_cur_nxt;
  evt_t   w_new, w_slot_data, w_disp;
  logic [7:0] r_data, w_data_nxt;
  logic [7:0] w_rom_addr;
  logic r_sym_clear, r_overflow;
  logic w_evt, w_idle, w_take_slot, w_take_new;
  logic w_push, w_slot_full, w_slot_ovf;
  logic w_in_wr, w_wr;

`ifdef MORSE_LINE_WRAP_EN
  logic [7:0] r_col, w_col_nxt, w_col_inc;
  assign w_col_inc = r_col + 8'd1;
`endif

  assign w_new = {bus.wg, bus.symbol_count, bus.symbol};
  assign w_evt = bus.lg | bus.wg;
  assign w_idle = (r_state == ST_IDLE);

  // The slot always drains before a fresh event is dispatched.
  assign w_take_slot = w_idle & w_slot_full;
  assign w_take_new  = w_idle & ~w_slot_full & w_evt;
  assign w_push      = w_evt & ~w_take_new;
  assign w_disp      = w_slot_full ? w_slot_data : w_new;

  assign w_in_wr = (r_state == ST_WR) || (r_state == ST_SP_WR) ||
                   (r_state == ST_CR_WR) || (r_state == ST_LF_WR);
  assign w_wr = w_in_wr & ~bus.tx_full;

  morse_evt_slot u_slot (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_pop     (w_take_slot),
    .i_data    (w_new),
    .o_data    (w_slot_data),
    .o_full    (w_slot_full),
    .o_overflow(w_slot_ovf)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_data_nxt  = r_data;
    w_rom_addr  = '0;
`ifdef MORSE_LINE_WRAP_EN
    w_col_nxt   = r_col;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (w_take_slot | w_take_new) begin
          w_cur_nxt = w_disp;
          if (w_disp.cnt != 3'd0)
            w_state_nxt = ST_LOOK;
          else if (w_disp.wg)
            w_state_nxt = ST_SP_LOOK;
        end
      end
      ST_LOOK: begin
        w_rom_addr  = {r_cur.cnt, r_cur.sym};
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        w_data_nxt  = (r_cur.cnt >= 3'd6) ? BAD_CHAR : bus.rom_data;
        w_state_nxt = ST_WR;
      end
      ST_WR: begin
        if (w_wr) begin
          w_state_nxt = r_cur.wg ? ST_SP_LOOK : ST_IDLE;
`ifdef MORSE_LINE_WRAP_EN
          w_col_nxt = w_col_inc;
          // A full line ends here; the pending space becomes the newline.
          if (32'(w_col_inc) >= LINE_LEN) begin
            w_state_nxt = ST_CR_WR;
            w_data_nxt  = ASCII_CR;
          end
`endif
        end
      end
      ST_SP_LOOK: begin
        w_rom_addr  = SPACE_ADDR;
        w_state_nxt = ST_SP_FETCH;
      end
      ST_SP_FETCH: begin
        w_data_nxt  = bus.rom_data;
        w_state_nxt = ST_SP_WR;
      end
      ST_SP_WR: begin
        if (w_wr) begin
          w_state_nxt = ST_IDLE;
`ifdef MORSE_LINE_WRAP_EN
          w_col_nxt = w_col_inc;
          if (32'(w_col_inc) + 32'd8 >= LINE_LEN) begin
            w_state_nxt = ST_CR_WR;
            w_data_nxt  = ASCII_CR;
          end
`endif
        end
      end
      ST_CR_WR: begin
        if (w_wr) begin
          w_state_nxt = ST_LF_WR;
          w_data_nxt  = ASCII_LF;
`ifdef MORSE_LINE_WRAP_EN
          w_col_nxt = w_col_inc;
`endif
        end
      end
      ST_LF_WR: begin
        if (w_wr) begin
          w_state_nxt = ST_IDLE;
`ifdef MORSE_LINE_WRAP_EN
          w_col_nxt = 8'd0;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cur       <= '0;
      r_data      <= '0;
      r_sym_clear <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur       <= w_cur_nxt;
      r_data      <= w_data_nxt;
      r_sym_clear <= w_evt & ~w_slot_ovf;
      r_overflow  <= w_slot_ovf;
    end
  end

`ifdef MORSE_LINE_WRAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_col <= 8'd0;
    else
      r_col <= w_col_nxt;
  end
`endif

  assign bus.rom_addr  = w_rom_addr;
  assign bus.w_data    = r_data;
  assign bus.wr_uart   = w_wr;
  assign bus.sym_clear = r_sym_clear;
  assign bus.busy      = ~w_idle;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Randomized self-checking bench for morse_tx_scheduler with a byte-stream model.
// Define MORSE_LINE_WRAP_EN to also cover wrapping at LINE_LEN=4.
module tb_morse_tx_scheduler;
  import morse_pkg::*;

  logic clk = 1'b0;
  logic reset;
  morse_tx_scheduler_if ifc();

  always #5 clk = ~clk;

`ifdef MORSE_LINE_WRAP_EN
  localparam int LL = 4;
  morse_tx_scheduler #(.LINE_LEN(LL)) dut (
    .clk(clk), .reset(reset), .bus(ifc));
`else
  morse_tx_scheduler dut (
    .clk(clk), .reset(reset), .bus(ifc));
`endif

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    case (a)
      8'hE0:   return 8'h20;
      8'h42:   return 8'h41;
      8'h21:   return 8'h45;
      default: return a ^ 8'hA5;
    endcase
  endfunction

  always @(posedge clk) ifc.rom_data <= rom_fn(ifc.rom_addr);

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] got_q[$];
  int n_clr = 0;
  int n_ovf = 0;
  int n_fullwr = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ifc.wr_uart) begin
        got_q.push_back(ifc.w_data);
        if (ifc.tx_full) n_fullwr++;
      end
      if (ifc.sym_clear) n_clr++;
      if (ifc.overflow) n_ovf++;
    end
  end

  logic [7:0] exp_q[$];
  int got_rd = 0;
  int m_col = 0;
  bit rnd_full = 1'b0;

  function automatic bit col_step(input bit is_sp);
`ifdef MORSE_LINE_WRAP_EN
    m_col++;
    if ((!is_sp && m_col >= LL) || (is_sp && m_col + 8 >= LL)) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_col = 0;
      return 1'b1;
    end
`else
    if (is_sp) return 1'b0;
`endif
    return 1'b0;
  endfunction

  // Expected UART bytes for one accepted event.
  task automatic model_evt(input logic l, input logic w,
                           input logic [2:0] c, input logic [4:0] s);
    bit wrapped;
    wrapped = 1'b0;
    if (!(l | w)) return;
    if (c != 3'd0) begin
      exp_q.push_back(c >= 3'd6 ? 8'h3F : rom_fn({c, s}));
      wrapped = col_step(1'b0);
    end
    if (w && !wrapped) begin
      exp_q.push_back(8'h20);
      void'(col_step(1'b1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_full) ifc.tx_full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send(input logic l, input logic w, input logic [2:0] c,
                      input logic [4:0] s, input bit keep);
    ifc.lg = l;
    ifc.wg = w;
    ifc.symbol_count = c;
    ifc.symbol = s;
    if (keep) model_evt(l, w, c, s);
    tick();
    ifc.lg = 1'b0;
    ifc.wg = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int quiet;
    quiet = 0;
    for (int n = 0; n < 500 && quiet < 3; n++) begin
      tick();
      quiet = ifc.busy ? 0 : quiet + 1;
    end
    chk(tag, quiet >= 3, 1);
  endtask

  task automatic cmp_stream(input string tag);
    int n;
    n = got_q.size() - got_rd;
    chk({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk($sformatf("%s_b%0d", tag, i), got_q[got_rd+i], exp_q[i]);
    got_rd = got_q.size();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ifc.lg = 1'b0;
    ifc.wg = 1'b0;
    ifc.tx_full = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    m_col = 0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c0, c1;
    reset = 1'b1;
    ifc.lg = 1'b0;
    ifc.wg = 1'b0;
    ifc.symbol = '0;
    ifc.symbol_count = '0;
    ifc.tx_full = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_addr", ifc.rom_addr, 0);
    chk("rst_wdata", ifc.w_data, 0);
    chk("rst_wr", ifc.wr_uart, 0);
    chk("rst_clr", ifc.sym_clear, 0);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_ovf", ifc.overflow, 0);
    reset = 1'b0;
    tick();

    // ".-" letter: address, latency, single sym_clear
    c0 = n_clr;
    send(1'b1, 1'b0, 3'd2, 5'b00010, 1'b1);
    chk("a_addr", ifc.rom_addr, 8'h42);
    chk("a_clr", ifc.sym_clear, 1);
    tick();
    @(negedge clk);
    chk("a_early", ifc.wr_uart, 0);
    tick();
    @(negedge clk);
    chk("a_wr", ifc.wr_uart, 1);
    chk("a_data", ifc.w_data, 8'h41);
    wait_idle("a_idle");
    cmp_stream("a");
    chk("a_clrcnt", n_clr - c0, 1);

    // word gap: 'E' then space
    send(1'b0, 1'b1, 3'd1, 5'd0, 1'b1);
    wait_idle("e_idle");
    cmp_stream("e");

    // tx_full stall in WR
    ifc.tx_full = 1'b1;
    send(1'b1, 1'b0, 3'd3, 5'd5, 1'b1);
    c0 = got_q.size();
    repeat (12) tick();
    chk("stall_none", got_q.size() - c0, 0);
    chk("stall_busy", ifc.busy, 1);
    ifc.tx_full = 1'b0;
    @(negedge clk);
    chk("stall_wr", ifc.wr_uart, 1);
    tick();
    @(negedge clk);
    chk("stall_once", ifc.wr_uart, 0);
    wait_idle("stall_idle");
    cmp_stream("stall");

    // back-to-back events: third one overflows
    c0 = n_ovf;
    c1 = n_clr;
    send(1'b1, 1'b0, 3'd2, 5'd1, 1'b1);
    send(1'b1, 1'b0, 3'd3, 5'd6, 1'b1);
    send(1'b0, 1'b1, 3'd4, 5'd9, 1'b0);
    wait_idle("ovf_idle");
    cmp_stream("ovf");
    chk("ovf_cnt", n_ovf - c0, 1);
    chk("ovf_clr", n_clr - c1, 2);

    // empty symbols
    send(1'b1, 1'b0, 3'd0, 5'd3, 1'b1);
    wait_idle("empty_lg_idle");
    send(1'b0, 1'b1, 3'd0, 5'd3, 1'b1);
    wait_idle("empty_wg_idle");
    cmp_stream("empty");

    // randomized events with random FIFO back-pressure
    rnd_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic l, w;
      l = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if (!l && !w) l = 1'b1;
      send(l, w, 3'($urandom_range(0, 7)), 5'($urandom), 1'b1);
      wait_idle("rnd_idle");
    end
    rnd_full = 1'b0;
    ifc.tx_full = 1'b0;
    cmp_stream("rnd");
    chk("no_wr_full", n_fullwr, 0);

    // count 7 sends '?', then reset while stalled in SP_WR
    do_reset();
    send(1'b0, 1'b1, 3'd7, 5'd3, 1'b0);
    exp_q.push_back(8'h3F);
    tick();
    tick();
    @(negedge clk);
    chk("bad_wr", ifc.wr_uart, 1);
    chk("bad_data", ifc.w_data, 8'h3F);
    tick();
    ifc.tx_full = 1'b1;
    repeat (3) tick();
    chk("sp_busy", ifc.busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_wr", ifc.wr_uart, 0);
    chk("mid_rst_busy", ifc.busy, 0);
    chk("mid_rst_wdata", ifc.w_data, 0);
    chk("mid_rst_addr", ifc.rom_addr, 0);
    tick();
    reset = 1'b0;
    ifc.tx_full = 1'b0;
    m_col = 0;
    tick();
    wait_idle("rst_idle");
    cmp_stream("rst");

`ifdef MORSE_LINE_WRAP_EN
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 1'b0, 3'd3, 5'(i + 1), 1'b1);
      wait_idle("wrap_idle");
    end
    chk("wrap_cr", got_q[got_rd+4], 8'h0D);
    chk("wrap_lf", got_q[got_rd+5], 8'h0A);
    cmp_stream("wrap");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
